// File: rtl/ising_run_ctrl_if.sv
// rtl/ising_run_ctrl_if.sv - register write strobe shared with weight loading
interface ising_run_ctrl_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;

  modport master (output wready, wr_addr, wdata);
  modport slave  (input  wready, wr_addr, wdata);
endinterface

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - run sequencer: matrix reset, anneal, phase sampling, spin readout
module ising_run_ctrl #(
  parameter int          N             = 3,
  parameter int          RESET_CYCLES  = 8,
  parameter int          SAMPLE_CYCLES = 64,
  parameter logic [31:0] CTRL_ADDR     = 32'h0000_0000,
  parameter logic [31:0] RUNTIME_ADDR  = 32'h0000_0004
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  ising_run_ctrl_if.slave      wr,
  input  logic [N-1:0]         osc_in_i,
  output logic                 ising_rstn_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N-1:0]         spins_o,
  output logic [31:0]          run_count_o
);
  localparam int MW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RESET, RUN, SAMPLE, DONE} state_e;

  state_e        state_q;
  logic [N-1:0]  sync1_q, sync2_q;
  logic [31:0]   run_time_q, run_len_q, cnt_q, run_count_q;
  logic [MW-1:0] mis_q [N];
  logic [MW-1:0] mis_d [N];
  logic [N-1:0]  spins_q, vote;
  logic          rstn_q, busy_q, done_q;
  logic          wr_ctrl, start, abort;

  assign wr_ctrl = wr.wready && (wr.wr_addr == CTRL_ADDR);
  assign abort   = wr_ctrl && wr.wdata[1];
  assign start   = wr_ctrl && wr.wdata[0] && !wr.wdata[1];

  // Tally includes the current cycle's compare so the exit vote sees all windows.
  always_comb begin
    vote = '0;
    for (int i = 0; i < N; i++) begin
      mis_d[i] = mis_q[i] + MW'(sync2_q[i] ^ sync2_q[0]);
      vote[i]  = (i != 0) && (32'(mis_d[i]) > 32'(SAMPLE_CYCLES / 2));
    end
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      run_time_q  <= 32'd1000;
      run_len_q   <= 32'd1;
      cnt_q       <= '0;
      run_count_q <= '0;
      spins_q     <= '0;
      rstn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N; i++) mis_q[i] <= '0;
    end else begin
      sync1_q <= osc_in_i;
      sync2_q <= sync1_q;
      if (wr.wready && (wr.wr_addr == RUNTIME_ADDR)) run_time_q <= wr.wdata;

      if (abort) begin
        state_q <= IDLE;
        rstn_q  <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q     <= RESET;
              cnt_q       <= '0;
              run_count_q <= '0;
              rstn_q      <= 1'b0;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end
          end
          RESET: begin
            cnt_q <= cnt_q + 32'd1;
            if (cnt_q == 32'(RESET_CYCLES - 1)) begin
              state_q   <= RUN;
              cnt_q     <= '0;
              rstn_q    <= 1'b1;
              run_len_q <= (run_time_q == 32'd0) ? 32'd1 : run_time_q;
              for (int i = 0; i < N; i++) mis_q[i] <= '0;
            end
          end
          RUN: begin
            cnt_q <= cnt_q + 32'd1;
            if (run_count_q != '1) run_count_q <= run_count_q + 32'd1;
            if (cnt_q == run_len_q - 32'd1) begin
              state_q <= SAMPLE;
              cnt_q   <= '0;
            end
          end
          SAMPLE: begin
            cnt_q <= cnt_q + 32'd1;
            for (int i = 0; i < N; i++) mis_q[i] <= mis_d[i];
            if (cnt_q == 32'(SAMPLE_CYCLES - 1)) begin
              state_q <= DONE;
              spins_q <= vote;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ising_rstn_o = rstn_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign spins_o      = spins_q;
  assign run_count_o  = run_count_q;
endmodule
